// File: rtl/serial_decoder.sv
// serial_decoder
// Serial-in / parallel-out receiver for an LSB-first bit stream. A sync pulse
// (qualified by serialValid) marks bit 0 of a message; after the first sync,
// frames run back-to-back. Completed messages enter a show-ahead FIFO read
// through a valid/ready handshake. Dropped messages and loss of alignment are
// reported through sticky flags.
//
// Ports
//   clock        in   rising-edge clock
//   resetN       in   asynchronous active-low reset
//   serialIn     in   serial data bit (LSB of each message first)
//   serialValid  in   serialIn carries a bit this cycle
//   syncIn       in   current valid bit is bit 0 of a message
//   message      out  FIFO head (WIDTH bits), meaningful while messageValid
//   messageValid out  FIFO not empty
//   messageReady in   consumer takes the head when messageValid is high
//   overrun      out  sticky: completed message dropped on a full FIFO
//   frameError   out  sticky: sync arrived in the middle of a message
//   clearFlags   in   synchronous clear of both sticky flags (a set wins)
//   level        out  FIFO occupancy, 0..DEPTH
//
// WIDTH must be at least 3; DEPTH must be a power of 2 and at least 2.

module serial_decoder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     serialIn,
  input  logic                     serialValid,
  input  logic                     syncIn,
  output logic [WIDTH-1:0]         message,
  output logic                     messageValid,
  input  logic                     messageReady,
  output logic                     overrun,
  output logic                     frameError,
  input  logic                     clearFlags,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Only the first WIDTH-1 bits are held; the last bit goes straight into the
  // pushed word, so the register never carries a dead bit.
  logic [WIDTH-2:0] shift_q, shift_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             push_s;
  logic [WIDTH-1:0] push_word_s;
  logic             fe_set_s;
  logic             pop_s;
  logic             full_s;
  logic             push_ok_s;
  logic             ovr_set_s;

  // Receive FSM: alignment hunt, bit assembly and frame completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    push_s      = 1'b0;
    fe_set_s    = 1'b0;
    push_word_s = {serialIn, shift_q};
    if (serialValid) begin
      case (state_q)
        HUNT: begin
          if (syncIn) begin
            shift_d = {serialIn, {(WIDTH-2){1'b0}}};
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end else begin
            state_d = HUNT;
          end
        end
        SHIFT: begin
          if (syncIn && (cnt_q != {CW{1'b0}})) begin
            // Realign: drop the partial message and restart at bit 0.
            fe_set_s = 1'b1;
            shift_d  = {serialIn, {(WIDTH-2){1'b0}}};
            cnt_d    = CW'(1);
          end else if (cnt_q == CW'(WIDTH-1)) begin
            push_s  = 1'b1;
            shift_d = {(WIDTH-1){1'b0}};
            cnt_d   = {CW{1'b0}};
          end else begin
            shift_d = {serialIn, shift_q[WIDTH-2:1]};
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = {CW{1'b0}};
          shift_d = {(WIDTH-1){1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FIFO control: a push into a full FIFO still succeeds when the head leaves
  // on the same edge.
  always_comb begin
    pop_s     = (level_q != {LW{1'b0}}) && messageReady;
    full_s    = (level_q == LW'(DEPTH));
    push_ok_s = push_s && (!full_s || pop_s);
    ovr_set_s = push_s && full_s && !pop_s;
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A flag-setting event beats a simultaneous clear.
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (clearFlags) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (fe_set_s) begin
      frame_err_d = 1'b1;
    end else if (clearFlags) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Receive state registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= HUNT;
      cnt_q   <= {CW{1'b0}};
      shift_q <= {(WIDTH-1){1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // FIFO storage, pointers, occupancy and sticky flags.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      level_q     <= {LW{1'b0}};
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_word_s;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      level_q     <= level_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Show-ahead head; storage is cleared on reset so message reads 0 then.
  assign message      = mem_q[rd_ptr_q];
  assign messageValid = (level_q != {LW{1'b0}});
  assign overrun      = overrun_q;
  assign frameError   = frame_err_q;
  assign level        = level_q;

endmodule

// File: tb/tb_serial_decoder.sv
module tb_serial_decoder;
  localparam int W = 8;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         resetN = 1'b0;
  logic         serialIn = 1'b0;
  logic         serialValid = 1'b0;
  logic         syncIn = 1'b0;
  logic         messageReady = 1'b0;
  logic         clearFlags = 1'b0;
  logic [W-1:0] message;
  logic         messageValid;
  logic         overrun;
  logic         frameError;
  logic [2:0]   level;

  serial_decoder #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .resetN(resetN), .serialIn(serialIn),
    .serialValid(serialValid), .syncIn(syncIn), .message(message),
    .messageValid(messageValid), .messageReady(messageReady),
    .overrun(overrun), .frameError(frameError), .clearFlags(clearFlags),
    .level(level)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int popped = 0;

  // Reference model: bit list of the frame in progress, alignment flag,
  // occupancy count and flags; accepted messages go to the scoreboard.
  bit         aligned = 1'b0;
  bit         fbits[$];
  int         m_level = 0;
  bit         m_ovr = 1'b0;
  bit         m_fe = 1'b0;
  logic [7:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the effect of the clock edge that just sampled the current inputs.
  task automatic model_edge();
    bit         pop, push, fe_set, ovr_set;
    logic [7:0] w;
    pop = (m_level > 0) && (messageReady === 1'b1);
    push = 1'b0; fe_set = 1'b0; ovr_set = 1'b0; w = 8'h00;
    if (serialValid) begin
      if (syncIn) begin
        if (aligned && fbits.size() != 0) fe_set = 1'b1;
        fbits.delete();
        aligned = 1'b1;
        fbits.push_back(serialIn);
      end else if (aligned) begin
        fbits.push_back(serialIn);
      end
      if (fbits.size() == W) begin
        for (int i = 0; i < W; i++) w[i] = fbits[i];
        fbits.delete();
        push = 1'b1;
      end
    end
    if (push && (m_level < D || pop)) begin
      sb.push_back(w);
      if (!pop) m_level++;
    end else begin
      if (push) ovr_set = 1'b1;
      if (pop) m_level--;
    end
    if (clearFlags) begin m_ovr = 1'b0; m_fe = 1'b0; end
    if (ovr_set) m_ovr = 1'b1;
    if (fe_set) m_fe = 1'b1;
  endtask

  task automatic model_reset();
    aligned = 1'b0; fbits.delete(); m_level = 0; m_ovr = 1'b0; m_fe = 1'b0; sb.delete();
  endtask

  // Monitor: compares visible state and pops the scoreboard on each handshake.
  always @(negedge clock) begin
    logic [7:0] e;
    check("level", {29'd0, level}, m_level);
    check("messageValid", {31'd0, messageValid}, {31'd0, m_level != 0});
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    check("frameError", {31'd0, frameError}, {31'd0, m_fe});
    if (messageValid === 1'b1 && messageReady === 1'b1) begin
      popped++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_message: got %h expected none", message);
      end else begin
        e = sb.pop_front();
        check("message", {24'd0, message}, {24'd0, e});
      end
    end
  end

  function automatic logic rdy(input int m);
    if (m == 2) return 1'($urandom_range(0, 1));
    return m[0];
  endfunction

  task automatic cyc(input logic v, input logic b, input logic s, input logic r, input logic c);
    @(posedge clock); #1;
    if (resetN) model_edge();
    serialValid = v; serialIn = b; syncIn = s; messageReady = r; clearFlags = c;
  endtask

  task automatic idle(input int n, input int rmode);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, rdy(rmode), 1'b0);
  endtask

  // Send one byte LSB-first with random idle gaps; idle cycles carry random
  // data and sync, which must be ignored.
  task automatic send_byte(input logic [7:0] d, input bit sync, input int rmode,
                           input int idle_max, input int last_rdy);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, idle_max))
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy(rmode), 1'b0);
      cyc(1'b1, d[i], 1'(sync && i == 0),
          (i == 7 && last_rdy >= 0) ? last_rdy[0] : rdy(rmode), 1'b0);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    model_edge();
    serialValid = 1'b0; serialIn = 1'b0; syncIn = 1'b0; messageReady = 1'b0; clearFlags = 1'b0;
    #1 resetN = 1'b0;
    model_reset();
    #1;
    check("rst_message", {24'd0, message}, 32'd0);
    check("rst_valid", {31'd0, messageValid}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_frameError", {31'd0, frameError}, 32'd0);
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
  endtask

  logic [7:0] t2 [4] = '{8'h01, 8'h80, 8'hFF, 8'h3C};

  initial begin
    #2;
    check("init_message", {24'd0, message}, 32'd0);
    check("init_valid", {31'd0, messageValid}, 32'd0);
    check("init_level", {29'd0, level}, 32'd0);
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;

    // 0xA5 with ready high
    send_byte(8'hA5, 1'b1, 1, 0, -1);
    idle(3, 1);
    check("t1_delivered", popped, 1);

    // continuous stream with gaps
    for (int k = 0; k < 4; k++) send_byte(t2[k], k == 0, 1, 2, -1);
    idle(4, 1);
    check("t2_delivered", popped, 5);
    check("t2_flags", {30'd0, overrun, frameError}, 32'd0);

    // overrun: five messages into a four-entry FIFO
    for (int k = 0; k < 5; k++) send_byte(8'(8'h10 + k), 1'b0, 0, 1, -1);
    idle(2, 0);
    check("t3_level_full", {29'd0, level}, 32'd4);
    check("t3_overrun", {31'd0, overrun}, 32'd1);
    idle(6, 1);
    check("t3_drained", popped, 9);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 0);
    check("t3_cleared", {31'd0, overrun}, 32'd0);

    // sync after three bits, then 0x5A
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b1, 1, 0, -1);
    idle(3, 1);
    check("t4_frameError", {31'd0, frameError}, 32'd1);
    check("t4_delivered", popped, 10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // full FIFO with a pop on the same edge as the completing bit
    for (int k = 0; k < 4; k++) send_byte(8'(8'hC0 + k), 1'b0, 0, 0, -1);
    send_byte(8'hE7, 1'b0, 0, 0, 1);
    idle(2, 0);
    check("t5_level", {29'd0, level}, 32'd4);
    check("t5_overrun", {31'd0, overrun}, 32'd0);
    idle(6, 1);
    check("t5_drained", popped, 15);

    // reset mid-message with queued entries and overrun set
    for (int k = 0; k < 5; k++) send_byte(8'(8'h20 + k), 1'b0, 0, 0, -1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1, 0);
    check("t6_pre_overrun", {31'd0, overrun}, 32'd1);
    do_reset();
    send_byte(8'h96, 1'b0, 1, 1, -1);
    send_byte(8'h69, 1'b0, 1, 1, -1);
    idle(3, 1);
    check("t6_no_messages", {29'd0, level}, 32'd0);
    check("t6_none_delivered", popped, 15);

    // randomized traffic
    for (int n = 0; n < 400; n++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    idle(8, 1);
    check("t7_scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_decoder.md
# serial_decoder

Serial-in/parallel-out receiver that consumes the LSB-first bit stream produced by the encoder's PISO stage and rebuilds 8-bit messages. An explicit sync pulse aligns it to the frame boundary. Completed messages go into a small show-ahead FIFO with a valid/ready handshake toward the consumer. Loss of alignment and dropped messages are reported through sticky flags.

## Interface
- `WIDTH`, 8: bits per message; the bit counter wraps at `WIDTH`.
- `DEPTH`, 4: FIFO entries; must be a power of 2 and at least 2.
- `clock` input 1: single clock; all state changes on its rising edge.
- `resetN` input 1: asynchronous, active-low reset.
- `serialIn` input 1: serial data bit; LSB of each message arrives first.
- `serialValid` input 1: `serialIn` carries a bit this cycle; when low, nothing is sampled.
- `syncIn` input 1: qualified by `serialValid`; marks the current bit as bit 0 of a message.
- `message` output `WIDTH`: FIFO head; valid only while `messageValid` is high.
- `messageValid` output 1: FIFO is not empty.
- `messageReady` input 1: consumer accepts `message` when both `messageValid` and `messageReady` are high.
- `overrun` output 1: sticky; a completed message was dropped because the FIFO was full.
- `frameError` output 1: sticky; a sync arrived while a message was only partly received.
- `clearFlags` input 1: synchronous clear of `overrun` and `frameError`.
- `level` output $clog2(DEPTH)+1: FIFO occupancy, from 0 to `DEPTH`.

## Operation
- Receive FSM has two states: HUNT and SHIFT.
- Reset state: HUNT, bit count 0, shift register 0, FIFO empty.
- While in reset, all outputs are 0: `message`=0, `messageValid`=0, `overrun`=0, `frameError`=0, `level`=0.
- HUNT state:
  - Bits are ignored until `serialValid` and `syncIn` are high together.
  - That bit is captured as bit 0, count becomes 1, and the FSM moves to SHIFT.
- SHIFT state, on each `serialValid` cycle:
  - Shift right and insert `serialIn` at the MSB, then increment the count.
  - After the `WIDTH`-th bit, the register holds the message with the first-received bit at bit 0.
  - The assembled word is pushed into the FIFO and the count returns to 0.
  - The FSM stays in SHIFT: frames are back-to-back and no sync is required after the first.
- Sync in SHIFT:
  - Sync at count 0 is consistent with alignment; no error is raised and the bit is taken as bit 0.
  - Sync at count 1 to `WIDTH`-1: the partial message is discarded, `frameError` is set, and the bit is taken as bit 0 (count becomes 1).
- FIFO push rules:
  - The push succeeds if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the message is dropped, `overrun` is set, and the FIFO contents are unchanged.
- FIFO pop: occurs when `messageValid` and `messageReady` are both high.
- Simultaneous push and pop: `level` is unchanged and ordering is preserved.
- Read and write pointers wrap modulo `DEPTH`.
- `clearFlags`: clears both sticky flags. If a flag-setting event happens in the same cycle, the set wins.
- `syncIn` without `serialValid` is ignored in every state.

## Timing
- Latency: the edge that samples the `WIDTH`-th bit writes the FIFO. `messageValid` and `message` update on that same edge, so they are visible 0 cycles after the sampling edge and settled for the next cycle.
- Show-ahead: `message` is driven from the FIFO head with no read latency. After a pop, the next entry appears on the same edge.
- Throughput: one message per `WIDTH` valid bits. A FIFO of depth 2 or more sustains a continuous stream while `messageReady` stays high.
- The sticky flags rise on the edge of the offending event.
- Asserting reset mid-message or with a non-empty FIFO:
  - Immediately clears the FSM, counter, FIFO, and flags.
  - The first message after release requires a new sync.

## Test plan
- Reset, then sync with the stream 0xA5 sent LSB-first (bits 1,0,1,0,0,1,0,1) with `messageReady`=1 → `messageValid` pulses high for 1 cycle after the 8th bit with `message`=0xA5; `level` returns to 0.
- Continuous stream 0x01, 0x80, 0xFF, 0x3C with `serialValid` toggling randomly → four messages delivered in order with no flags set.
- `messageReady`=0, send 5 messages with `DEPTH`=4 → `level`=4, 5th message dropped, `overrun`=1. After draining, the outputs read the first 4 messages in order. `clearFlags` → `overrun`=0.
- After a sync and 3 bits, a second sync followed by byte 0x5A → `frameError`=1, output 0x5A only, and no partial message is ever pushed.
- FIFO full with `messageReady`=1 on the same edge the 8th bit arrives → push and pop both occur, `level` stays 4, `overrun` stays 0.
- Assert `resetN` low mid-message with 2 entries queued → all outputs read 0 at once. Bits sent after release without a sync produce no messages.
